// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// seq_divider : restoring shift-subtract divider, one quotient bit per clock.
//   Produces div_ans = {remainder, quotient}. Optional signed mode: SEQ_DIV_SIGNED_EN.
//   Revision : 1.0
// ============================================================================
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic               is_signed,
`endif
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] div_ans
);

  localparam int            CNT_W      = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [2*WIDTH-1:0] ans_q, ans_d;

  logic               can_accept;
  logic               divisor_zero;
  logic [WIDTH-1:0]   mag_dividend, mag_divisor;
  logic [WIDTH:0]     shifted_rem;
  logic               trial_ge;
  logic [WIDTH-1:0]   rem_next, quot_next;
  logic [WIDTH-1:0]   rem_res, quot_res;

  assign can_accept   = start && (state_q != RUN);
  assign divisor_zero = (divisor == '0);

  // The trial window is WIDTH+1 bits so a divisor with its MSB set never overflows.
  assign shifted_rem = {rem_q, quot_q[WIDTH-1]};
  assign trial_ge    = (shifted_rem >= {1'b0, dvs_q});
  assign rem_next    = trial_ge ? (shifted_rem[WIDTH-1:0] - dvs_q) : shifted_rem[WIDTH-1:0];
  assign quot_next   = {quot_q[WIDTH-2:0], trial_ge};

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;
  logic dividend_neg, divisor_neg;

  assign dividend_neg = is_signed & dividend[WIDTH-1];
  assign divisor_neg  = is_signed & divisor[WIDTH-1];
  assign mag_dividend = dividend_neg ? -dividend : dividend;
  assign mag_divisor  = divisor_neg ? -divisor : divisor;
  assign quot_res     = neg_quot_q ? -quot_next : quot_next;
  assign rem_res      = neg_rem_q ? -rem_next : rem_next;

  always_comb begin
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    if (can_accept && !divisor_zero) begin
      neg_quot_d = dividend_neg ^ divisor_neg;
      neg_rem_d  = dividend_neg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end
`else
  assign mag_dividend = dividend;
  assign mag_divisor  = divisor;
  assign quot_res     = quot_next;
  assign rem_res      = rem_next;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    ans_d   = ans_q;
    case (state_q)
      RUN: begin
        rem_d   = rem_next;
        quot_d  = quot_next;
        count_d = count_q + 1'b1;
        if (count_q == LAST_COUNT) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dbz_d   = 1'b0;
          ans_d   = {rem_res, quot_res};
        end
      end
      default: begin
        // IDLE and DONE accept a new op identically, allowing back-to-back issue.
        state_d = IDLE;
        busy_d  = 1'b0;
        if (can_accept) begin
          if (divisor_zero) begin
            state_d = DONE;
            done_d  = 1'b1;
            dbz_d   = 1'b1;
            ans_d   = {dividend, {WIDTH{1'b1}}};
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            rem_d   = '0;
            quot_d  = mag_dividend;
            dvs_d   = mag_divisor;
            count_d = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ans_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ans_q   <= ans_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign div_ans     = ans_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// tb_seq_divider : directed and random checks of seq_divider against an arithmetic model.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
`ifdef SEQ_DIV_SIGNED_EN
  logic         is_signed = 1'b0;
`endif
  logic           busy;
  logic           done;
  logic           div_by_zero;
  logic [2*W-1:0] div_ans;

  int total = 0;
  int passed = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
`ifdef SEQ_DIV_SIGNED_EN
    .is_signed(is_signed),
`endif
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .div_ans(div_ans)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: plain integer division; signed ops use 64-bit signed arithmetic.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
`ifdef SEQ_DIV_SIGNED_EN
    is_signed = sgn;
`else
    if (sgn) $display("note: signed op requested in unsigned build");
`endif
  endtask

  // Called at the negedge just after an accepting edge; steps until done is seen.
  task automatic wait_done(input int poke_at, output int edges, output int busy_cnt, output bit seen);
    edges = 0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (edges == poke_at) begin
        start    = 1'b1;
        dividend = $urandom;
        divisor  = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit sgn, input int poke_at);
    logic [63:0] exp;
    int edges, bc;
    bit seen, z;
    exp = ref_div(a, b, sgn);
    z   = (b == 32'd0);
    @(negedge clk);
    issue(a, b, sgn);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    wait_done(poke_at, edges, bc, seen);
    check($sformatf("%s.done", tag), 64'(seen), 64'd1);
    check($sformatf("%s.latency", tag), 64'(edges), 64'(z ? 0 : W));
    check($sformatf("%s.busy_cycles", tag), 64'(bc), 64'(z ? 0 : W));
    check($sformatf("%s.ans", tag), div_ans, exp);
    check($sformatf("%s.dbz", tag), 64'(div_by_zero), 64'(z));
    @(negedge clk);
    check($sformatf("%s.strobe", tag), 64'(done), 64'd0);
    check($sformatf("%s.hold", tag), div_ans, exp);
  endtask

  initial begin
    int edges, bc, pulses;
    bit seen;
    logic [31:0] a, b;

    repeat (3) @(negedge clk);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.dbz", 64'(div_by_zero), 64'd0);
    check("reset.ans", div_ans, 64'd0);
    rst = 1'b0;

    run_op("t1_100_7", 32'd100, 32'd7, 1'b0, -1);
    check("t1.const", div_ans, 64'h00000002_0000000E);

    run_op("t2_5_0", 32'd5, 32'd0, 1'b0, -1);
    check("t2.const", div_ans, 64'h00000005_FFFFFFFF);

    run_op("t3_ffff_8000", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 10);
    check("t3.const", div_ans, 64'h7FFFFFFF_00000001);

    // Reset in the middle of a run aborts it.
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4.busy", 64'(busy), 64'd0);
    check("t4.done", 64'(done), 64'd0);
    check("t4.ans", div_ans, 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    check("t4.quiet", 64'(pulses), 64'd0);
    run_op("t4_9_3", 32'd9, 32'd3, 1'b0, -1);
    check("t4.const", div_ans, 64'h00000000_00000003);

    // Back-to-back: start held through DONE.
    @(negedge clk);
    issue(32'd100, 32'd7, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done(-1, edges, bc, seen);
    check("t5.first_done", 64'(seen), 64'd1);
    issue(32'd20, 32'd6, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("t5.rerun_busy", 64'(busy), 64'd1);
    check("t5.rerun_done", 64'(done), 64'd0);
    wait_done(-1, edges, bc, seen);
    check("t5.second_done", 64'(seen), 64'd1);
    check("t5.latency", 64'(edges), 64'(W));
    check("t5.ans", div_ans, 64'h00000002_00000003);
    check("t5.dbz", 64'(div_by_zero), 64'd0);

    run_op("b_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, -1);
    run_op("b_zero_num", 32'd0, 32'd5, 1'b0, -1);
    run_op("b_small_big", 32'd7, 32'd9, 1'b0, -1);
    run_op("b_eq", 32'h1234_5678, 32'h1234_5678, 1'b0, -1);

    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = 32'h8000_0000 | $urandom;
        default: b = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      run_op($sformatf("rnd%0d", i), a, b, 1'b0, (i % 3 == 0) ? $urandom_range(0, 30) : -1);
    end

`ifdef SEQ_DIV_SIGNED_EN
    run_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, -1);
    check("s_m7_2.const", div_ans, 64'hFFFFFFFF_FFFFFFFD);
    run_op("u_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0, -1);
    check("u_m7_2.const", div_ans, 64'h00000001_7FFFFFFC);
    run_op("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);
    check("s_min_m1.const", div_ans, 64'h00000000_80000000);
    run_op("s_div0", 32'hFFFF_FFF9, 32'd0, 1'b1, -1);
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? $urandom : (32'hFFFF_FF00 | $urandom_range(1, 255));
      run_op($sformatf("srnd%0d", i), a, b, 1'b1, -1);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
